// File: rtl/drac_pkg.sv
// drac_pkg: shared types, widths and helpers for the iterative divider.
package drac_pkg;
  localparam int XLEN_MAX = 64;
  localparam int DIV_CNT_W = $clog2(XLEN_MAX + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
  typedef struct packed {
    logic [XLEN_MAX-1:0] dividend;
    logic [XLEN_MAX-1:0] divisor;
    logic                is_signed;
    logic                rem;
    logic                word;
  } div_req_t;
  function automatic logic [XLEN_MAX-1:0] sext32(input logic [31:0] x);
    return {{(XLEN_MAX-32){x[31]}}, x};
  endfunction
endpackage

// File: rtl/iter_div_unit_div_step.sv
// div_step: one combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);
  logic [XLEN:0]   sh;
  logic [XLEN-1:0] diff;
  always_comb begin
    sh    = {rem_i, bit_i};
    diff  = sh[XLEN-1:0] - divisor_i;
    q_o   = sh >= {1'b0, divisor_i};
    rem_o = q_o ? diff : sh[XLEN-1:0];
  end
endmodule

// File: rtl/iter_div_unit.sv
// iter_div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU and W variants.
// Define DIV_EARLY_OUT_EN to finish x/0 and |a|<|b| directly after accept.
module iter_div_unit
  import drac_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter bit HAS_WORD_OPS = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            kill_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            signed_i,
  input  logic            rem_i,
  input  logic            word_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);
  div_state_t state_q, state_d;
  div_req_t req;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] q_q, q_d, r_q, r_d, d_q, d_d, result_q, result_d;
  logic rem_q, rem_d, word_q, word_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, r_step, q_step, raw, fixed, res_fin;
  logic a_neg, b_neg, div0, q_bit, accept;
  assign req = '{dividend: XLEN_MAX'(dividend_i), divisor: XLEN_MAX'(divisor_i),
                 is_signed: signed_i, rem: rem_i, word: word_i & HAS_WORD_OPS};
  always_comb begin
    a_ext  = req.word ? (req.is_signed ? XLEN'(sext32(req.dividend[31:0])) : XLEN'(req.dividend[31:0]))
                      : req.dividend[XLEN-1:0];
    b_ext  = req.word ? (req.is_signed ? XLEN'(sext32(req.divisor[31:0])) : XLEN'(req.divisor[31:0]))
                      : req.divisor[XLEN-1:0];
    a_neg  = req.is_signed & a_ext[XLEN-1];
    b_neg  = req.is_signed & b_ext[XLEN-1];
    mag_a  = a_neg ? -a_ext : a_ext;
    mag_b  = b_neg ? -b_ext : b_ext;
    div0   = b_ext == '0;
    accept = valid_i & ready_o & ~kill_i;
  end
  div_step #(.XLEN(XLEN)) u_step (
    .rem_i    (r_q),
    .bit_i    (q_q[XLEN-1]),
    .divisor_i(d_q),
    .rem_o    (r_step),
    .q_o      (q_bit)
  );
  // Divide-by-zero keeps an all-ones quotient because q_neg is cleared at accept.
  always_comb begin
    q_step  = {q_q[XLEN-2:0], q_bit};
    raw     = rem_q ? r_step : q_step;
    fixed   = (rem_q ? r_neg_q : q_neg_q) ? -raw : raw;
    res_fin = word_q ? XLEN'(sext32(fixed[31:0])) : fixed;
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    r_d      = r_q;
    d_d      = d_q;
    rem_d    = rem_q;
    word_d   = word_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    if (state_q == IDLE && accept) begin
      state_d = BUSY;
      cnt_d   = req.word ? DIV_CNT_W'(32) : DIV_CNT_W'(XLEN);
      q_d     = req.word ? mag_a << 32 : mag_a;
      r_d     = '0;
      d_d     = mag_b;
      rem_d   = req.rem;
      word_d  = req.word;
      q_neg_d = req.is_signed & (a_neg ^ b_neg) & ~div0;
      r_neg_d = a_neg;
`ifdef DIV_EARLY_OUT_EN
      if (div0 || mag_a < mag_b) begin
        state_d  = DONE;
        result_d = req.rem ? (req.word ? XLEN'(sext32(req.dividend[31:0])) : req.dividend[XLEN-1:0])
                           : (div0 ? '1 : '0);
      end
`endif
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - DIV_CNT_W'(1);
      q_d   = q_step;
      r_d   = r_step;
      if (cnt_q == DIV_CNT_W'(1)) begin
        state_d  = DONE;
        result_d = res_fin;
      end
    end else if (state_q == DONE && ready_i) begin
      state_d = IDLE;
    end
    state_d = kill_i ? IDLE : state_d;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      q_q      <= '0;
      r_q      <= '0;
      d_q      <= '0;
      rem_q    <= 1'b0;
      word_q   <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      r_q      <= r_d;
      d_q      <= d_d;
      rem_q    <= rem_d;
      word_q   <= word_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end
  assign ready_o  = state_q == IDLE;
  assign busy_o   = state_q != IDLE;
  assign valid_o  = state_q == DONE;
  assign result_o = result_q;
endmodule

// File: doc/iter_div_unit.md
Name: iter_div_unit

Overview:
- Multi-cycle radix-2 restoring integer divider covering RISC-V M-extension DIV/DIVU/REM/REMU, plus the W variants when enabled.
- Sits in the execute stage next to the single-cycle integer ALU, so the ALU no longer needs a combinational divide.
- Valid/ready handshake on the request side and on the result side; a kill input flushes in-flight work on mispredict or exception.
- Parametrised in data width, with an optional 32-bit word mode.

Parameters:
- XLEN, 64, operand and result width in bits (32 or 64).
- HAS_WORD_OPS, 1, enables word_i handling (only legal when XLEN=64; tie to 0 when XLEN=32).

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  synchronous reset, active-high
- kill_i  input  1  flush: abort any request in progress, drop any pending result
- valid_i  input  1  request valid
- ready_o  output  1  unit can accept a request
- dividend_i  input  XLEN  rs1 operand
- divisor_i  input  XLEN  rs2 operand
- signed_i  input  1  1 = signed op (DIV/REM), 0 = unsigned
- rem_i  input  1  1 = return remainder, 0 = return quotient
- word_i  input  1  1 = W-op: use low 32 bits, sign-extend the 32-bit result
- valid_o  output  1  result valid
- ready_i  input  1  consumer accepts result
- result_o  output  XLEN  quotient or remainder
- busy_o  output  1  state is not IDLE

Behaviour:
- Reset values: state=IDLE, valid_o=0, ready_o=1, busy_o=0, result_o=0. Internal counter and registers are cleared.
- FSM states: IDLE, BUSY, DONE.
- ready_o = (state==IDLE).
- accept = valid_i & ready_o & ~kill_i.
- IDLE -> BUSY on accept. On that edge, latch the magnitudes of both operands, the result sign, the remainder sign, rem_i and word_i, and set counter=N.
- N = 32 if word_i is set, otherwise XLEN.
- BUSY: each cycle do one restoring step (shift partial remainder, trial subtract, set quotient bit) and decrement the counter. The transition to DONE happens on the edge that performs the last step.
- DONE: valid_o=1. result_o is sign-corrected, selected per rem_i, and registered; it is held stable while ready_i=0. DONE -> IDLE on ready_i.
- Latency: accept in cycle T gives valid_o=1 in cycle T+N+1 (65 cycles for XLEN=64, 33 for W-ops). Throughput is one op per N+2 cycles minimum; there is no accept while in DONE.
- Signed ops: the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.
- Word mode: operands are the low 32 bits, sign-extended if signed_i, zero-extended otherwise. The 32-bit result is always sign-extended to XLEN, including DIVUW/REMUW.
- Divide by zero: quotient = all ones; remainder = dividend (the word-extended dividend in word mode). The sign fix-up must not be applied.
- Overflow (most-negative / -1, signed): quotient = dividend, remainder = 0.
- kill_i in BUSY or DONE: next state is IDLE, valid_o=0 next cycle, and the result is lost. kill_i in IDLE blocks accept.
- kill_i and ready_i together in DONE: go to IDLE with no difference in behaviour.
- rst_i has priority over kill_i and behaves identically at any point mid-operation.
- Inputs are sampled only at accept; changes to them during BUSY are ignored.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: if the divisor is zero, or the unsigned magnitude of the dividend is less than that of the divisor, accept goes straight to DONE. valid_o is then high in cycle T+1, with quotient = 0 (or all ones for divide by zero) and remainder = dividend.
- Not defined: every operation, including divide by zero, takes the full N+1 latency. Results are bit-identical in both builds.

Decomposition:
- drac_pkg additions:
  - div_state_t enum (IDLE/BUSY/DONE)
  - div_req_t struct {dividend, divisor, signed, rem, word}
  - DIV_CNT_W = $clog2(XLEN+1)
- Sub-module div_step: combinational single restoring iteration (partial remainder in, quotient bit and next remainder out), parametrised by XLEN.

Test Plan:
- Unsigned 100 / 7, rem_i=0 then rem_i=1 -> result 14 then 2; valid_o asserted exactly 65 cycles after accept (XLEN=64).
- Signed -7 / 2 -> quotient 0xFFFF_FFFF_FFFF_FFFD, remainder 0xFFFF_FFFF_FFFF_FFFF.
- 5 / 0 signed and unsigned -> quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 5. With DIV_EARLY_OUT_EN defined, the same values arrive with latency 1.
- Overflow corner cases:
  - Signed 0x8000_0000_0000_0000 / -1 -> quotient 0x8000_0000_0000_0000, remainder 0.
  - DIVW with dividend 0x0000_0001_8000_0000 and divisor -1 -> 0xFFFF_FFFF_8000_0000, latency 33.
  - DIVUW 0xFFFF_FFFF / 1 -> 0xFFFF_FFFF_FFFF_FFFF.
- kill_i pulsed 10 cycles after accept -> valid_o never rises, ready_o=1 next cycle, and the following request 9 / 3 returns 3 correctly.
- ready_i held low 5 cycles in DONE -> valid_o and result_o stable, ready_o=0. ready_i high -> IDLE next cycle. rst_i during BUSY -> all outputs return to reset values next cycle.
